hd_denetleyici: RTL and testbench

Symbol scheduler between `huffman_decoder` and the run-length/dequantisation stage of the JPEG baseline decoder. It accepts `(run, cat)` symbols from the decoder and selects the Huffman table for the next symbol: DC/AC, luma/chroma. It tracks the zig-zag coefficient index inside each 8x8 block and walks the block/component order of every MCU. It forwards each symbol tagged with position, component and end-of-block, and reports scan completion or a bitstream error.

---
 rtl/hd_denetleyici_if.sv | 30 +++
 rtl/hd_denetleyici.sv | 190 +++++++++++++++++++
 tb/tb_hd_denetleyici.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hd_denetleyici_if.sv
// Symbol streams around the JPEG symbol scheduler: decoder -> scheduler -> dequantiser.
interface hd_denetleyici_if #(
  parameter int RUN_BIT = 4,
  parameter int CAT_BIT = 4
);
  logic [RUN_BIT-1:0] hd_run;
  logic [CAT_BIT-1:0] hd_cat;
  logic               hd_gecerli;
  logic               hd_hazir;
  logic [1:0]         hd_tablo;
  logic [RUN_BIT-1:0] ns_run;
  logic [CAT_BIT-1:0] ns_cat;
  logic [5:0]         ns_indis;
  logic [1:0]         ns_bilesen;
  logic               ns_blok_son;
  logic               ns_gecerli;
  logic               ns_hazir;

  // Decoder and downstream stage together drive this side.
  modport master (
    output hd_run, hd_cat, hd_gecerli, ns_hazir,
    input  hd_hazir, hd_tablo, ns_run, ns_cat, ns_indis, ns_bilesen, ns_blok_son, ns_gecerli
  );

  // The scheduler itself.
  modport slave (
    input  hd_run, hd_cat, hd_gecerli, ns_hazir,
    output hd_hazir, hd_tablo, ns_run, ns_cat, ns_indis, ns_bilesen, ns_blok_son, ns_gecerli
  );
endinterface

// File: rtl/hd_denetleyici.sv
// Symbol scheduler: picks the Huffman table for the next symbol, tracks the
// zig-zag index per block and the Y/Cb/Cr block order per MCU.
//
// state | meaning
// BOSTA | idle, waiting for baslat_i
// DC    | expecting the DC symbol of a block
// AC    | expecting AC symbols (run/cat) until EOB or index 63
// HATA  | bitstream error seen, waiting for baslat_i
module hd_denetleyici #(
  parameter int RUN_BIT    = 4,
  parameter int CAT_BIT    = 4,
  parameter int MCU_Y_BLOK = 4,
  parameter int MCU_BIT    = 16
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic               baslat_i,
  input  logic [MCU_BIT-1:0] mcu_sayisi_i,
  hd_denetleyici_if.slave    bus,
  output logic               bitti_o,
  output logic               hata_o
);
  typedef enum logic [1:0] {BOSTA, DC, AC, HATA} durum_t;

  localparam logic [2:0] NY       = 3'(MCU_Y_BLOK);
  localparam logic [2:0] SON_BLOK = 3'(MCU_Y_BLOK + 1);

  durum_t             durum, durum_d;
  logic [6:0]         idx, idx_d, p;
  logic [2:0]         blok, blok_d;
  logic [MCU_BIT-1:0] mcu, mcu_d, mcu_top, mcu_top_d;
  logic               hata_d, bitti_d, yukle, son_d, blok_bitti, kabul;
  logic [5:0]         indis_d;
  logic [1:0]         tablo_q, tablo_d;

  logic [RUN_BIT-1:0] ns_run_q;
  logic [CAT_BIT-1:0] ns_cat_q;
  logic [5:0]         ns_indis_q;
  logic [1:0]         ns_bilesen_q;
  logic               ns_son_q, ns_gecerli_q;

  // Block position within the MCU -> component (Y blocks first, then Cb, Cr).
  function automatic logic [1:0] bilesen_of(input logic [2:0] b);
    if (b < NY) return 2'd0;
    if (b == NY) return 2'd1;
    return 2'd2;
  endfunction

  assign bus.hd_hazir    = (durum == DC || durum == AC) && (!ns_gecerli_q || bus.ns_hazir);
  assign bus.hd_tablo    = tablo_q;
  assign bus.ns_run      = ns_run_q;
  assign bus.ns_cat      = ns_cat_q;
  assign bus.ns_indis    = ns_indis_q;
  assign bus.ns_bilesen  = ns_bilesen_q;
  assign bus.ns_blok_son = ns_son_q;
  assign bus.ns_gecerli  = ns_gecerli_q;

  assign kabul = bus.hd_gecerli && bus.hd_hazir;
  assign p     = idx + 7'(bus.hd_run);

  // Next state, counters and the emit decision for the symbol accepted this cycle.
  always_comb begin
    durum_d    = durum;
    idx_d      = idx;
    blok_d     = blok;
    mcu_d      = mcu;
    mcu_top_d  = mcu_top;
    hata_d     = hata_o;
    bitti_d    = 1'b0;
    yukle      = 1'b0;
    indis_d    = 6'd0;
    son_d      = 1'b0;
    blok_bitti = 1'b0;
    case (durum)
      BOSTA, HATA: begin
        if (baslat_i) begin
          mcu_top_d = mcu_sayisi_i;
          blok_d    = 3'd0;
          mcu_d     = '0;
          idx_d     = 7'd0;
          hata_d    = 1'b0;
          if (mcu_sayisi_i == '0) begin
            bitti_d = 1'b1;
            durum_d = BOSTA;
          end else begin
            durum_d = DC;
          end
        end
      end
      DC: begin
        if (kabul) begin
          yukle   = 1'b1;
          idx_d   = 7'd1;
          durum_d = AC;
        end
      end
      AC: begin
        if (kabul) begin
          if (bus.hd_cat == '0) begin
            if (bus.hd_run == '0) begin
              yukle      = 1'b1;
              indis_d    = idx[5:0];
              son_d      = 1'b1;
              blok_bitti = 1'b1;
            end else if (bus.hd_run == RUN_BIT'(15) && (idx + 7'd16) <= 7'd63) begin
              yukle   = 1'b1;
              indis_d = idx[5:0];
              idx_d   = idx + 7'd16;
            end else begin
              durum_d = HATA;
              hata_d  = 1'b1;
            end
          end else if (p > 7'd63) begin
            durum_d = HATA;
            hata_d  = 1'b1;
          end else begin
            yukle      = 1'b1;
            indis_d    = p[5:0];
            son_d      = (p == 7'd63);
            blok_bitti = (p == 7'd63);
            idx_d      = p + 7'd1;
          end
        end
      end
      default: durum_d = BOSTA;
    endcase
    if (blok_bitti) begin
      idx_d = 7'd0;
      if (blok == SON_BLOK) begin
        blok_d = 3'd0;
        mcu_d  = mcu + MCU_BIT'(1);
        if (mcu + MCU_BIT'(1) == mcu_top) begin
          bitti_d = 1'b1;
          durum_d = BOSTA;
        end else begin
          durum_d = DC;
        end
      end else begin
        blok_d  = blok + 3'd1;
        durum_d = DC;
      end
    end
    // Table select follows the state/block it will apply to, so it moves on the same edge.
    tablo_d = {bilesen_of(blok_d) != 2'd0, durum_d == AC};
  end

  // State, counters, table select and status flags.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      durum   <= BOSTA;
      idx     <= 7'd0;
      blok    <= 3'd0;
      mcu     <= '0;
      mcu_top <= '0;
      tablo_q <= 2'd0;
      bitti_o <= 1'b0;
      hata_o  <= 1'b0;
    end else begin
      durum   <= durum_d;
      idx     <= idx_d;
      blok    <= blok_d;
      mcu     <= mcu_d;
      mcu_top <= mcu_top_d;
      tablo_q <= tablo_d;
      bitti_o <= bitti_d;
      hata_o  <= hata_d;
    end
  end

  // Single-entry output register; holds its payload while downstream stalls.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      ns_run_q     <= '0;
      ns_cat_q     <= '0;
      ns_indis_q   <= 6'd0;
      ns_bilesen_q <= 2'd0;
      ns_son_q     <= 1'b0;
      ns_gecerli_q <= 1'b0;
    end else if (yukle) begin
      ns_run_q     <= bus.hd_run;
      ns_cat_q     <= bus.hd_cat;
      ns_indis_q   <= indis_d;
      ns_bilesen_q <= bilesen_of(blok);
      ns_son_q     <= son_d;
      ns_gecerli_q <= 1'b1;
    end else if (bus.ns_hazir) begin
      ns_gecerli_q <= 1'b0;
    end
  end
endmodule

// File: tb/tb_hd_denetleyici.sv
// Randomised bench for hd_denetleyici (4:2:0 configuration) with a
// position-tracking reference model and an expected-output queue.
module tb_hd_denetleyici;
  localparam int NY = 4;

  logic        clk, rstn, baslat, bitti, hata;
  logic [15:0] mcu_sayisi;

  hd_denetleyici_if #(.RUN_BIT(4), .CAT_BIT(4)) hd_if ();

  hd_denetleyici #(.RUN_BIT(4), .CAT_BIT(4), .MCU_Y_BLOK(NY), .MCU_BIT(16)) dut (
    .clk_i(clk), .rstn_i(rstn), .baslat_i(baslat), .mcu_sayisi_i(mcu_sayisi),
    .bus(hd_if), .bitti_o(bitti), .hata_o(hata)
  );

  int n_test = 0, n_fail = 0, n_out = 0, bitti_cnt = 0, b0 = 0, cyc = 0, pos = 0;
  bit bp_rand = 0, bp_hold = 0;
  logic [16:0] exp_q[$];

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic kontrol(input string tag, input logic [31:0] gozlem, input logic [31:0] beklenen);
    n_test++;
    if (gozlem !== beklenen) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, gozlem, beklenen);
    end
  endtask

  // Downstream ready: constant 1, random, or held by a test.
  initial begin
    hd_if.ns_hazir = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      if (!bp_hold) hd_if.ns_hazir = bp_rand ? ($urandom % 4 != 0) : 1'b1;
    end
  end

  // Output monitor: compares every handshake against the model, checks stall stability.
  initial begin
    logic [16:0] cur, held;
    bit stall_prev;
    stall_prev = 0;
    held = '0;
    forever begin
      @(negedge clk);
      if (bitti) bitti_cnt++;
      cur = {hd_if.ns_run, hd_if.ns_cat, hd_if.ns_indis, hd_if.ns_bilesen, hd_if.ns_blok_son};
      if (stall_prev && hd_if.ns_gecerli) kontrol("stall_hold", 32'(cur), 32'(held));
      stall_prev = hd_if.ns_gecerli && !hd_if.ns_hazir;
      held = cur;
      if (hd_if.ns_gecerli && hd_if.ns_hazir) begin
        n_out++;
        if (exp_q.size() == 0) kontrol("extra_out", 1, 0);
        else kontrol("out", 32'(cur), 32'(exp_q.pop_front()));
      end
    end
  end

  function automatic logic [1:0] bil_of(input int b);
    if (b < NY) return 2'd0;
    if (b == NY) return 2'd1;
    return 2'd2;
  endfunction

  // Reference: position arithmetic straight from the symbol rules.
  task automatic model(input logic [3:0] r, input logic [3:0] c, input bit ac, input logic [1:0] bil);
    int ix;
    bit son;
    ix = 0;
    son = 0;
    if (!ac) begin
      ix = 0;
      pos = 1;
    end else if (c == 0 && r == 0) begin
      ix = pos;
      son = 1;
    end else if (c == 0) begin
      ix = pos;
      pos += 16;
    end else begin
      ix = pos + int'(r);
      son = (ix == 63);
      pos = ix + 1;
    end
    exp_q.push_back({r, c, 6'(ix), bil, son});
  endtask

  // Present one symbol; returns #1 after the edge that accepted it.
  task automatic send(input logic [3:0] r, input logic [3:0] c, input logic [1:0] tab);
    bit ok;
    ok = 0;
    hd_if.hd_run = r;
    hd_if.hd_cat = c;
    hd_if.hd_gecerli = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (hd_if.hd_hazir) begin
        ok = 1;
        kontrol("tablo", 32'(hd_if.hd_tablo), 32'(tab));
      end
      @(posedge clk);
      #1;
    end
    if (!ok) kontrol("accept_timeout", 0, 1);
  endtask

  task automatic push_sym(input logic [3:0] r, input logic [3:0] c, input bit ac, input logic [1:0] bil);
    model(r, c, ac, bil);
    send(r, c, {bil != 2'd0, ac});
  endtask

  // mode 0: random AC content, 1: DC + EOB, 2: DC + 63 coefficients
  task automatic do_block(input int mode, input logic [1:0] bil);
    bit done;
    int k, mx, r;
    pos = 0;
    push_sym(4'd0, 4'($urandom_range(0, 11)), 0, bil);
    if (mode == 1) push_sym(4'd0, 4'd0, 1, bil);
    else if (mode == 2) repeat (63) push_sym(4'd0, 4'd1, 1, bil);
    else begin
      done = 0;
      while (!done) begin
        k = $urandom % 8;
        if (k == 0) begin
          push_sym(4'd0, 4'd0, 1, bil);
          done = 1;
        end else if (k == 1 && pos + 16 <= 63) begin
          push_sym(4'd15, 4'd0, 1, bil);
        end else begin
          mx = 63 - pos;
          if (mx > 15) mx = 15;
          r = $urandom_range(0, mx);
          push_sym(4'(r), 4'($urandom_range(1, 10)), 1, bil);
          if (pos == 64) done = 1;
        end
      end
    end
  endtask

  task automatic wait_drain();
    bit ok;
    ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !hd_if.ns_gecerli) ok = 1;
    end
    if (!ok) kontrol("drain_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic start_scan(input int n);
    b0 = bitti_cnt;
    mcu_sayisi = 16'(n);
    baslat = 1'b1;
    @(posedge clk);
    #1;
    baslat = 1'b0;
    kontrol("hata_clear", 32'(hata), 0);
  endtask

  task automatic finish_scan();
    hd_if.hd_gecerli = 1'b0;
    @(negedge clk);
    kontrol("bitti_pulse", 32'(bitti), 1);
    wait_drain();
    kontrol("bitti_count", bitti_cnt - b0, 1);
    kontrol("hazir_idle", 32'(hd_if.hd_hazir), 0);
  endtask

  task automatic run_scan(input int n, input int mode);
    start_scan(n);
    for (int m = 0; m < n; m++)
      for (int b = 0; b < NY + 2; b++) do_block(mode, bil_of(b));
    finish_scan();
  endtask

  initial begin
    int o0, acc, c0, nz;
    rstn = 1'b0;
    baslat = 1'b0;
    mcu_sayisi = '0;
    hd_if.hd_run = '0;
    hd_if.hd_cat = '0;
    hd_if.hd_gecerli = 1'b0;
    #3;
    kontrol("rst_hs", 32'({hd_if.hd_hazir, hd_if.hd_tablo, hd_if.ns_gecerli}), 0);
    kontrol("rst_payload", 32'({hd_if.ns_run, hd_if.ns_cat, hd_if.ns_indis, hd_if.ns_bilesen, hd_if.ns_blok_son}), 0);
    kontrol("rst_flags", 32'({bitti, hata}), 0);
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // 4:2:0, one MCU, DC + EOB in every block
    o0 = n_out;
    run_scan(1, 1);
    kontrol("n_out_420", n_out - o0, 12);

    // AC run arithmetic: indices 0, 6, 7, 23, 24
    start_scan(1);
    pos = 0;
    push_sym(4'd0, 4'd2, 0, 2'd0);
    push_sym(4'd5, 4'd3, 1, 2'd0);
    push_sym(4'd15, 4'd0, 1, 2'd0);
    push_sym(4'd0, 4'd1, 1, 2'd0);
    push_sym(4'd0, 4'd0, 1, 2'd0);
    for (int b = 1; b < NY + 2; b++) do_block(1, bil_of(b));
    finish_scan();

    // Full blocks with no EOB
    run_scan(1, 2);

    // Overflow at idx 61 with run 3, then recovery
    start_scan(1);
    pos = 0;
    push_sym(4'd0, 4'd5, 0, 2'd0);
    repeat (60) push_sym(4'd0, 4'd1, 1, 2'd0);
    send(4'd3, 4'd1, 2'b01);
    hd_if.hd_gecerli = 1'b0;
    wait_drain();
    kontrol("ovf_hata", 32'(hata), 1);
    kontrol("ovf_hazir", 32'(hd_if.hd_hazir), 0);
    bp_rand = 1;
    run_scan(1, 0);

    // Back-pressure: 5 stalled cycles, exactly one accept, then full rate
    bp_rand = 0;
    start_scan(1);
    bp_hold = 1;
    hd_if.ns_hazir = 1'b0;
    pos = 0;
    acc = 0;
    model(4'd0, 4'd7, 0, 2'd0);
    hd_if.hd_run = 4'd0;
    hd_if.hd_cat = 4'd7;
    hd_if.hd_gecerli = 1'b1;
    @(negedge clk);
    if (hd_if.hd_hazir) acc++;
    @(posedge clk);
    #1;
    model(4'd0, 4'd0, 1, 2'd0);
    hd_if.hd_cat = 4'd0;
    repeat (4) begin
      @(negedge clk);
      if (hd_if.hd_hazir) acc++;
      @(posedge clk);
      #1;
    end
    kontrol("bp_accepts", acc, 1);
    bp_hold = 0;
    hd_if.ns_hazir = 1'b1;
    send(4'd0, 4'd0, 2'b01);
    c0 = cyc;
    for (int b = 1; b < NY + 2; b++) do_block(1, bil_of(b));
    kontrol("bp_rate", cyc - c0, 10);
    finish_scan();

    // Zero MCUs: immediate bitti, never ready
    start_scan(0);
    @(negedge clk);
    kontrol("zero_bitti", 32'(bitti), 1);
    nz = 0;
    repeat (5) begin
      @(negedge clk);
      if (hd_if.hd_hazir) nz = 1;
    end
    kontrol("zero_hazir", nz, 0);
    kontrol("zero_count", bitti_cnt - b0, 1);
    @(posedge clk);
    #1;

    // Random scans under random back-pressure
    bp_rand = 1;
    for (int s = 0; s < 4; s++) run_scan($urandom_range(1, 3), 0);

    // Reset in the middle of a scan
    bp_rand = 0;
    repeat (2) @(posedge clk);
    #1;
    start_scan(2);
    pos = 0;
    push_sym(4'd0, 4'd3, 0, 2'd0);
    push_sym(4'd1, 4'd2, 1, 2'd0);
    rstn = 1'b0;
    #1;
    kontrol("midrst_gec", 32'(hd_if.ns_gecerli), 0);
    kontrol("midrst_tab", 32'(hd_if.hd_tablo), 0);
    kontrol("midrst_haz", 32'(hd_if.hd_hazir), 0);
    hd_if.hd_gecerli = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1;
    rstn = 1'b1;
    @(posedge clk);
    #1;
    run_scan(1, 1);

    $display("[TB] %0d tests run, %0d failed", n_test, n_fail);
    $finish;
  end
endmodule
